// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller, one outstanding memory request.
// Latency: load hit returns data the cycle after acceptance; a miss returns it the cycle after mem_ack.
// Backpressure: cpu_ready is high only in IDLE; memory requests are held stable until mem_ack.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module data_cache_ctrl #(
    parameter int LINES = 4,
    parameter int IDX_W = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ready,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } state_t;

    state_t             state;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [31:0]        data_mem [LINES];

    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               lookup_hit;
    logic               accept;
    logic               load_hit;
    logic               load_miss;
    logic               store_hit;
    logic               fill;

    // Byte offset bits are architecturally ignored.
    logic               unused_byte_off;
    assign unused_byte_off = &{1'b0, cpu_addr[1:0]};

    // The in-flight fill target is recovered from the held memory address.
    assign req_idx    = cpu_addr[IDX_W+1:2];
    assign req_tag    = cpu_addr[31:IDX_W+2];
    assign fill_idx   = mem_addr[IDX_W+1:2];
    assign fill_tag   = mem_addr[31:IDX_W+2];

    assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign accept     = (state == IDLE) && cpu_req;
    // A flush in the same cycle as a load forces that load to miss.
    assign load_hit   = accept && !cpu_we && lookup_hit && !flush;
    assign load_miss  = accept && !cpu_we && !(lookup_hit && !flush);
    assign store_hit  = accept && cpu_we && lookup_hit;
    assign fill       = (state == RD_MISS) && mem_ack;

    assign cpu_ready  = (state == IDLE);

    // Controller FSM with registered CPU response and memory request outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= 32'h0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
        end else begin
            cpu_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_hit) begin
                        cpu_rvalid <= 1'b1;
                        cpu_rdata  <= data_mem[req_idx];
                    end else if (load_miss) begin
                        state    <= RD_MISS;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {cpu_addr[31:2], 2'b00};
                    end else if (accept) begin
                        state     <= WR_THRU;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {cpu_addr[31:2], 2'b00};
                        mem_wdata <= cpu_wdata;
                    end
                end
                RD_MISS: begin
                    if (mem_ack) begin
                        state      <= IDLE;
                        mem_req    <= 1'b0;
                        cpu_rvalid <= 1'b1;
                        cpu_rdata  <= mem_rdata;
                    end
                end
                WR_THRU: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Valid bits: flush wins over a coincident fill so the line stays invalid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (fill) begin
            valid[fill_idx] <= 1'b1;
        end
    end

    // Tag/data storage needs no reset since every use is qualified by valid.
    always_ff @(posedge clock) begin
        if (fill) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_rdata;
        end else if (store_hit) begin
            data_mem[req_idx] <= cpu_wdata;
        end
    end

`ifdef DCACHE_STATS_EN
    // Saturating per-load hit/miss counters, cleared only by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_count  <= 16'h0;
            miss_count <= 16'h0;
        end else begin
            if (load_hit && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'h1;
            end
            if (load_miss && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'h1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Self-checking bench for data_cache_ctrl: directed scenarios then randomized traffic.
// Expected results come from a line-level cache model plus a word-addressed memory model.
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
module tb_data_cache_ctrl;

    logic        clock;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: 4 direct-mapped lines and a sparse backing memory.
    bit          m_valid [4];
    logic [27:0] m_tag   [4];
    logic [31:0] m_data  [4];
    logic [31:0] mem_model [logic [31:0]];
    int          exp_hits;
    int          exp_misses;

    data_cache_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] wa);
        if (mem_model.exists(wa)) return mem_model[wa];
        return wa ^ 32'hA5C3_0F00;
    endfunction

    // One complete CPU transaction, with optional flush at acceptance or at mem_ack,
    // and an optional spurious CPU request injected while the controller is busy.
    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int lat, input bit fl_acc, input bit fl_ack,
                          input bit ign_req, input string tag);
        logic [31:0] wa;
        logic [31:0] rd;
        int          idx;
        bit          hit;
        wa  = {addr[31:2], 2'b00};
        idx = int'(addr[3:2]);
        hit = !fl_acc && m_valid[idx] && (m_tag[idx] == addr[31:4]);

        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        flush     = fl_acc;
        chk({tag, ":ready_at_req"}, cpu_ready, 1);
        tick();
        cpu_req  = 1'b0;
        flush    = 1'b0;
        cpu_addr = $urandom;
        if (fl_acc) model_clear();

        if (!we && hit) begin
            exp_hits++;
            chk({tag, ":hit_rvalid"}, cpu_rvalid, 1);
            chk({tag, ":hit_rdata"}, cpu_rdata, m_data[idx]);
            chk({tag, ":hit_no_memreq"}, mem_req, 0);
            return;
        end
        if (!we) exp_misses++;
        if (we && hit) m_data[idx] = wdata;

        chk({tag, ":mem_req"}, mem_req, 1);
        chk({tag, ":mem_we"}, mem_we, we);
        chk({tag, ":mem_addr"}, mem_addr, wa);
        if (we) chk({tag, ":mem_wdata"}, mem_wdata, wdata);
        chk({tag, ":busy_rvalid"}, cpu_rvalid, 0);
        chk({tag, ":busy_ready"}, cpu_ready, 0);

        for (int i = 1; i < lat; i++) begin
            if (ign_req && i == 1) begin
                cpu_req   = 1'b1;
                cpu_we    = 1'b0;
                cpu_addr  = 32'h0000_003C;
                cpu_wdata = 32'hFFFF_0000;
            end
            tick();
            chk({tag, ":hold_req"}, mem_req, 1);
            chk({tag, ":hold_we"}, mem_we, we);
            chk({tag, ":hold_addr"}, mem_addr, wa);
            if (we) chk({tag, ":hold_wdata"}, mem_wdata, wdata);
            chk({tag, ":hold_ready"}, cpu_ready, 0);
            chk({tag, ":hold_rvalid"}, cpu_rvalid, 0);
        end
        cpu_req = 1'b0;

        rd        = mem_val(wa);
        mem_ack   = 1'b1;
        mem_rdata = we ? $urandom : rd;
        flush     = fl_ack;
        tick();
        mem_ack   = 1'b0;
        flush     = 1'b0;
        mem_rdata = $urandom;
        if (fl_ack) model_clear();

        if (!we) begin
            chk({tag, ":fill_rvalid"}, cpu_rvalid, 1);
            chk({tag, ":fill_rdata"}, cpu_rdata, rd);
            if (!fl_ack) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = addr[31:4];
                m_data[idx]  = rd;
            end
        end else begin
            chk({tag, ":wr_no_rvalid"}, cpu_rvalid, 0);
            mem_model[wa] = wdata;
        end
        chk({tag, ":done_memreq"}, mem_req, 0);
        chk({tag, ":done_ready"}, cpu_ready, 1);
    endtask

    initial begin
        logic [31:0] a;
        bit          w;

        cpu_req    = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = 32'h0;
        cpu_wdata  = 32'h0;
        flush      = 1'b0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;
        exp_hits   = 0;
        exp_misses = 0;
        model_clear();

        // Reset state.
        reset = 1'b0;
        #2;
        chk("rst:rvalid", cpu_rvalid, 0);
        chk("rst:rdata", cpu_rdata, 0);
        chk("rst:mem_req", mem_req, 0);
        chk("rst:mem_we", mem_we, 0);
        chk("rst:mem_addr", mem_addr, 0);
        chk("rst:mem_wdata", mem_wdata, 0);
        tick();
        tick();
        reset = 1'b1;
        chk("rst:ready_after_release", cpu_ready, 1);
        tick();

        // Cold load then repeat hit.
        mem_model[32'h10] = 32'hDEAD_BEEF;
        access(0, 32'h10, 0, 3, 0, 0, 0, "cold_miss");
        access(0, 32'h10, 0, 1, 0, 0, 0, "cold_hit");

        // Conflict on index 1.
        access(0, 32'h04, 0, 2, 0, 0, 0, "conf_a");
        access(0, 32'h14, 0, 2, 0, 0, 0, "conf_b");
        access(0, 32'h04, 0, 2, 0, 0, 0, "conf_a_again");

        // Store hit updates line; store miss does not allocate.
        access(0, 32'h08, 0, 2, 0, 0, 0, "st_fill");
        access(1, 32'h08, 32'h1234_5678, 2, 0, 0, 0, "st_hit");
        access(0, 32'h08, 0, 1, 0, 0, 0, "st_readback");
        access(1, 32'h30, 32'h0BAD_F00D, 2, 0, 0, 0, "st_miss");
        access(0, 32'h30, 0, 2, 0, 0, 0, "st_noalloc");

        // Long handshake with an ignored request in the middle.
        access(1, 32'h0C, 32'hCAFE_0001, 10, 0, 0, 1, "hold_wr");
        access(0, 32'h2C, 0, 10, 0, 0, 1, "hold_rd");

        // Flush during fill, then flush coinciding with an IDLE load.
        access(0, 32'h18, 0, 3, 0, 1, 0, "fl_fill");
        access(0, 32'h18, 0, 2, 0, 0, 0, "fl_refetch");
        access(0, 32'h18, 0, 2, 1, 0, 0, "fl_at_req");

        // Reset in the middle of a write-through, then a late ack.
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 32'h20;
        cpu_wdata = 32'h7777_7777;
        tick();
        cpu_req = 1'b0;
        chk("rstmid:mem_req_before", mem_req, 1);
        tick();
        reset = 1'b0;
        #1;
        chk("rstmid:mem_req", mem_req, 0);
        chk("rstmid:mem_we", mem_we, 0);
        chk("rstmid:mem_addr", mem_addr, 0);
        chk("rstmid:rvalid", cpu_rvalid, 0);
        tick();
        reset = 1'b1;
        model_clear();
        exp_hits   = 0;
        exp_misses = 0;
        chk("rstmid:ready_release", cpu_ready, 1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_2222;
        tick();
        mem_ack = 1'b0;
        chk("late_ack:rvalid", cpu_rvalid, 0);
        chk("late_ack:mem_req", mem_req, 0);
        chk("late_ack:ready", cpu_ready, 1);

        // Two misses and three hits.
        access(0, 32'h40, 0, 2, 0, 0, 0, "stats_m1");
        access(0, 32'h40, 0, 1, 0, 0, 0, "stats_h1");
        access(0, 32'h44, 0, 2, 0, 0, 0, "stats_m2");
        access(0, 32'h44, 0, 1, 0, 0, 0, "stats_h2");
        access(0, 32'h40, 0, 1, 0, 0, 0, "stats_h3");
`ifdef DCACHE_STATS_EN
        chk("stats:hit_count", hit_count, 3);
        chk("stats:miss_count", miss_count, 2);
`endif

        // Randomized traffic over a small address footprint to force hits and conflicts.
        for (int n = 0; n < 300; n++) begin
            a = ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            a = a | ($urandom_range(0, 1) << 20);
            w = ($urandom_range(0, 9) < 3);
            access(w, a, $urandom, $urandom_range(1, 4),
                   $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, 0, "rnd");
            if ($urandom_range(0, 3) == 0) begin
                tick();
                chk("rnd:idle_rvalid", cpu_rvalid, 0);
            end
        end
`ifdef DCACHE_STATS_EN
        chk("rnd:hit_count", hit_count, exp_hits[15:0]);
        chk("rnd:miss_count", miss_count, exp_misses[15:0]);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_cache_ctrl.md
DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

Interface
REQ-001 SHALL have parameter LINES, default 4, meaning number of direct-mapped lines (power of two, >= 2).
REQ-002 SHALL have parameter IDX_W, default 2, meaning log2(LINES); index is addr[IDX_W+1:2], tag is addr[31:IDX_W+2].
REQ-003 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports cpu_req  input  1 (request valid); cpu_we  input  1 (1 = store, 0 = load); cpu_addr  input  32 (byte address, bits [1:0] ignored); cpu_wdata  input  32 (store data).
REQ-006 SHALL have ports cpu_ready  output  1 (request accepted this cycle if cpu_req=1); cpu_rvalid  output  1 (one-cycle load-data pulse); cpu_rdata  output  32 (load data, valid only with cpu_rvalid).
REQ-007 SHALL have port flush  input  1  invalidates all lines.
REQ-008 SHALL have ports mem_req  output  1; mem_we  output  1; mem_addr  output  32 (word-aligned, [1:0]=0); mem_wdata  output  32 -- backing-memory request.
REQ-009 SHALL have ports mem_ack  input  1 (request complete); mem_rdata  input  32 (read data, valid with mem_ack).

Function
REQ-010 SHALL implement FSM states IDLE, RD_MISS, WR_THRU; cpu_ready=1 only in IDLE.
REQ-011 SHALL, in IDLE with cpu_req=1 and cpu_we=0 on a hit (line valid, tag equal), pulse cpu_rvalid with line data the next cycle, remain in IDLE, and accept back-to-back requests.
REQ-012 SHALL, on load miss, go to RD_MISS, asserting mem_req=1, mem_we=0, mem_addr={cpu_addr[31:2],2'b00} from the next cycle.
REQ-013 SHALL, in RD_MISS on mem_ack, write mem_rdata, tag and valid=1 into the line, pulse cpu_rvalid with cpu_rdata=mem_rdata the next cycle, and return to IDLE.
REQ-014 SHALL, on any accepted store, go to WR_THRU with mem_req=1, mem_we=1, mem_wdata=cpu_wdata; on a store hit the line data is updated at acceptance; a store miss does not allocate.
REQ-015 SHALL, in WR_THRU on mem_ack, return to IDLE without asserting cpu_rvalid.
REQ-016 SHALL hold mem_req, mem_we, mem_addr and mem_wdata registered and stable from assertion until the cycle mem_ack is sampled high; mem_req deasserts the cycle after ack.
REQ-017 SHALL ignore mem_ack while in IDLE.
REQ-018 SHALL ignore cpu_req while cpu_ready=0; the requester holds its request.
REQ-019 SHALL, on flush=1, clear every valid bit at that edge in any state; when flush coincides with an RD_MISS fill, the data still returns on cpu_rvalid but the line stays invalid.
REQ-020 SHALL, when flush coincides with an IDLE load request, evaluate that request as a miss.
REQ-021 SHALL keep cpu_rvalid=0 in every cycle not listed in REQ-011/REQ-013.

Reset
REQ-022 SHALL, while reset=0, force state IDLE, all valid bits 0, cpu_rvalid=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, immediately and independent of clock.
REQ-023 SHALL abandon any in-flight RD_MISS/WR_THRU on reset without a cpu_rvalid pulse; a late mem_ack after release is ignored.
REQ-024 SHALL have cpu_ready=1 in the first cycle after reset release.

Configuration
REQ-025 SHALL, when macro DCACHE_STATS_EN is defined, add outputs hit_count  output  16 and miss_count  output  16, incremented per accepted load hit/miss, saturating at 16'hFFFF, cleared by reset only.
REQ-026 SHALL, when DCACHE_STATS_EN is undefined, omit those ports and counters with all other behaviour identical.

Verification
REQ-027 SHALL cover cold load: load 0x0000_0010, mem_ack with 0xDEAD_BEEF after 3 cycles -> one mem read at 0x10, cpu_rvalid with 0xDEAD_BEEF the cycle after ack; repeat load -> rvalid next cycle, no mem_req.
REQ-028 SHALL cover conflict: load 0x04 then 0x14 (same index 1) -> both miss; reload 0x04 -> misses again.
REQ-029 SHALL cover store hit: after filling 0x08, store 0x1234_5678 to 0x08 -> mem write 0x08/0x1234_5678; subsequent load 0x08 hits returning 0x1234_5678; store to uncached 0x30 -> later load 0x30 misses.
REQ-030 SHALL cover handshake stability: mem_ack delayed 10 cycles -> mem_addr/mem_wdata/mem_we constant, cpu_ready=0 throughout, new cpu_req ignored.
REQ-031 SHALL cover flush and reset: flush during RD_MISS fill -> data returned, next load same address misses; reset low mid-WR_THRU -> mem_req=0 immediately, no rvalid, cpu_ready=1 after release.
REQ-032 SHALL cover, with DCACHE_STATS_EN, 3 hits and 2 misses -> hit_count=3, miss_count=2.
